// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// vga_timing_pkg - 640x480@60 timing defaults and 160x120 framebuffer geometry
// Revision 1.0
// ============================================================================
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int FB_AW    = 15;

  typedef logic [2:0]       colour_t;
  typedef logic [FB_AW-1:0] fb_addr_t;

  // row*160 + col as (row<<7)+(row<<5)+col so no multiplier is inferred
  function automatic fb_addr_t fb_addr(input logic [6:0] row, input logic [7:0] col);
    fb_addr_t w_row;
    w_row = fb_addr_t'(row);
    return (w_row << 7) + (w_row << 5) + fb_addr_t'(col);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_ram_2p.sv
`default_nettype none
// ============================================================================
// fb_ram_2p - simple dual-port framebuffer RAM, sync read, old data on collision
// Revision 1.0
// ============================================================================
module fb_ram_2p
  import vga_timing_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH,
  parameter int AW    = FB_AW
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  colour_t       i_wdata,
  input  logic [AW-1:0] i_raddr,
  output colour_t       o_rdata
);

  colour_t r_mem [DEPTH];
  colour_t r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/frame_scanout.sv
`default_nettype none
// ============================================================================
// frame_scanout - plot-port framebuffer with post-reset scrub and 4x-scaled VGA scanout
// Revision 1.0
// ============================================================================
module frame_scanout #(
  parameter vga_timing_pkg::colour_t BG_COLOUR = 3'b000,
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FP      = vga_timing_pkg::H_FP,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BP      = vga_timing_pkg::H_BP,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FP      = vga_timing_pkg::V_FP,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BP      = vga_timing_pkg::V_BP
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              x,
  input  logic [6:0]              y,
  input  vga_timing_pkg::colour_t colour,
  input  logic                    plot,
  output logic                    busy,
  output logic                    VGA_CLK,
  output logic                    VGA_HS,
  output logic                    VGA_VS,
  output logic                    VGA_BLANK_N,
  output logic                    VGA_SYNC_N,
  output logic [9:0]              VGA_R,
  output logic [9:0]              VGA_G,
  output logic [9:0]              VGA_B
);
  import vga_timing_pkg::*;

  localparam logic [9:0] c_h_vis    = 10'(H_VISIBLE);
  localparam logic [9:0] c_hs_start = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] c_hs_end   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] c_h_last   = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] c_v_vis    = 10'(V_VISIBLE);
  localparam logic [9:0] c_vs_start = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] c_vs_end   = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0] c_v_last   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam fb_addr_t   c_fb_last  = fb_addr_t'(FB_DEPTH - 1);

  localparam logic [0:0] c_st_clear = 1'b0;
  localparam logic [0:0] c_st_run   = 1'b1;

  logic       r_pix_en, r_vga_clk;
  logic [9:0] r_h_cnt, r_v_cnt;
  logic [0:0] r_state;
  fb_addr_t   r_clr_addr;
  fb_addr_t   r_rd_addr;
  logic       r_hs1, r_vs1, r_vis1;
  logic       r_hs2, r_vs2, r_vis2;
  colour_t    r_rgb;

  logic       w_vis, w_hs, w_vs, w_clearing, w_plot_ok, w_we;
  fb_addr_t   w_rd_addr, w_waddr;
  colour_t    w_wdata, w_rdata;

  assign w_vis = (r_h_cnt < c_h_vis) && (r_v_cnt < c_v_vis);
  assign w_hs  = !((r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end));
  assign w_vs  = !((r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end));
  // Blanked positions map past the RAM, so they read cell 0 instead
  assign w_rd_addr = w_vis ? fb_addr(r_v_cnt[8:2], r_h_cnt[9:2]) : '0;

  assign w_clearing = (r_state == c_st_clear);
  assign w_plot_ok  = plot && (x < 8'(FB_W)) && (y < 7'(FB_H));
  assign w_we       = w_clearing || w_plot_ok;
  assign w_waddr    = w_clearing ? r_clr_addr : fb_addr(y, x);
  assign w_wdata    = w_clearing ? BG_COLOUR : colour;

  fb_ram_2p u_fb_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_addr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix_en  <= 1'b0;
      r_vga_clk <= 1'b0;
    end else begin
      r_pix_en  <= ~r_pix_en;
      r_vga_clk <= r_pix_en;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_pix_en) begin
      if (r_h_cnt == c_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  // Sync/blank ride alongside the RAM read so every output lags the counters by two ticks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_addr <= '0;
      r_hs1     <= 1'b1;
      r_vs1     <= 1'b1;
      r_vis1    <= 1'b0;
      r_hs2     <= 1'b1;
      r_vs2     <= 1'b1;
      r_vis2    <= 1'b0;
      r_rgb     <= '0;
    end else if (r_pix_en) begin
      r_rd_addr <= w_rd_addr;
      r_hs1     <= w_hs;
      r_vs1     <= w_vs;
      r_vis1    <= w_vis;
      r_hs2     <= r_hs1;
      r_vs2     <= r_vs1;
      r_vis2    <= r_vis1;
      r_rgb     <= r_vis1 ? w_rdata : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= c_st_clear;
      r_clr_addr <= '0;
    end else if (r_state == c_st_clear) begin
      if (r_clr_addr == c_fb_last) begin
        r_state <= c_st_run;
      end else begin
        r_clr_addr <= r_clr_addr + fb_addr_t'(1);
      end
    end
  end

  assign busy        = w_clearing;
  assign VGA_CLK     = r_vga_clk;
  assign VGA_HS      = r_hs2;
  assign VGA_VS      = r_vs2;
  assign VGA_BLANK_N = r_vis2;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = {10{r_rgb[2]}};
  assign VGA_G       = {10{r_rgb[1]}};
  assign VGA_B       = {10{r_rgb[0]}};

endmodule
`default_nettype wire
